// File: rtl/io_bus_arbiter_pkg.sv
// Shared types for the IO bus arbiter: bus words, latched request and FSM states.
// Also holds the modular pointer increment used by the round-robin logic.
package io_bus_arbiter_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    logic  rw;
    byte_t addr;
    word_t wdata;
  } io_req_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2,
    WAIT_REL = 2'd3
  } arb_state_t;

  localparam int TIMER_W = 16;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Zero latency; vld low when no request is pending.
module io_bus_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  int          cand;
  logic [IW-1:0] c;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = 0;
    c    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      c = IW'(cand);
      if (req[c]) begin
        vld = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin owner of the shared register IO bus; one grant per 4-phase handshake, with watchdog abort.
// s_hs1 rises 2 cycles after a request is seen; other masters simply wait until the handshake fully returns.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter  int N_MASTERS      = 2,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int IW             = $clog2(N_MASTERS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_MASTERS-1:0]  m_hs1,
  input  logic [N_MASTERS-1:0]  m_rw,
  input  byte_t [N_MASTERS-1:0] m_addr,
  input  word_t [N_MASTERS-1:0] m_wdata,
  output logic [N_MASTERS-1:0]  m_hs2,
  output logic [N_MASTERS-1:0]  m_err,
  output word_t                 m_rdata,
  output logic                  s_hs1,
  output logic                  s_rw,
  output byte_t                 s_addr,
  output word_t                 s_wdata,
  input  logic                  s_hs2,
  input  word_t                 s_rdata,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_inc;
  io_req_t              req_q, req_d;
  logic                 s_hs1_q, s_hs1_d;
  logic [N_MASTERS-1:0] m_hs2_q, m_hs2_d;
  logic [N_MASTERS-1:0] m_err_q, m_err_d;
  word_t                m_rdata_q, m_rdata_d;
  logic                 busy_q, busy_d;

  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;

  io_bus_arbiter_rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_rr_pick (
    .req (m_hs1),
    .ptr (rr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    timer_d   = timer_q;
    req_d     = req_q;
    s_hs1_d   = s_hs1_q;
    m_hs2_d   = m_hs2_q;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        // A slave still holding its acknowledge must settle before anyone is granted.
        if (pick_vld && !s_hs2) begin
          req_d.rw    = m_rw[pick_idx];
          req_d.addr  = m_addr[pick_idx];
          req_d.wdata = m_wdata[pick_idx];
          gnt_d       = pick_idx;
          state_d     = REQ;
        end
      end
      REQ: begin
        s_hs1_d = 1'b1;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        timer_d = timer_inc;
        if (s_hs2) begin
          m_rdata_d      = s_rdata;
          m_hs2_d[gnt_q] = 1'b1;
          s_hs1_d        = 1'b0;
          state_d        = WAIT_REL;
        end else if (timer_inc == TIMER_W'(TIMEOUT_CYCLES)) begin
          m_err_d[gnt_q] = 1'b1;
          m_hs2_d[gnt_q] = 1'b1;
          s_hs1_d        = 1'b0;
          state_d        = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!m_hs1[gnt_q] && !s_hs2) begin
          m_hs2_d = '0;
          m_err_d = '0;
          rr_d    = IW'(wrap_inc(32'(gnt_q), 32'(N_MASTERS)));
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gnt_q     <= '0;
      timer_q   <= '0;
      req_q     <= '0;
      s_hs1_q   <= 1'b0;
      m_hs2_q   <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
      s_hs1_q   <= s_hs1_d;
      m_hs2_q   <= m_hs2_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign m_hs2    = m_hs2_q;
  assign m_err    = m_err_q;
  assign m_rdata  = m_rdata_q;
  assign s_hs1    = s_hs1_q;
  assign s_rw     = req_q.rw;
  assign s_addr   = req_q.addr;
  assign s_wdata  = req_q.wdata;
  assign grant_id = gnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: read, contention, timeout, ack-on-timeout, latch freeze, stale slave, async reset.
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  m_hs1 = '0;
  logic [1:0]  m_rw = '0;
  byte_t [1:0] m_addr = '0;
  word_t [1:0] m_wdata = '0;
  logic [1:0]  m_hs2, m_err;
  word_t       m_rdata;
  logic        s_hs1, s_rw;
  byte_t       s_addr;
  word_t       s_wdata;
  logic        s_hs2 = 1'b0;
  word_t       s_rdata = '0;
  logic [0:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  io_bus_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .m_hs1(m_hs1), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_hs2(m_hs2), .m_err(m_err), .m_rdata(m_rdata),
    .s_hs1(s_hs1), .s_rw(s_rw), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_hs2(s_hs2), .s_rdata(s_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_s_hs1(input string tag);
    int n = 0;
    while (s_hs1 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(s_hs1), 32'd1);
  endtask

  // Slave side of one transaction: ack one cycle after s_hs1, then master releases.
  task automatic do_xact(input string tag, input int exp_g, input word_t rdata, input logic rereq);
    int   g;
    logic [1:0] exp_h;
    wait_s_hs1({tag, "_rise"});
    g = int'(grant_id);
    chk({tag, "_grant"}, 32'(g), 32'(exp_g));
    tick();
    s_hs2   = 1'b1;
    s_rdata = rdata;
    tick();
    exp_h = 2'b01 << exp_g;
    chk({tag, "_hs2"}, 32'(m_hs2), 32'(exp_h));
    chk({tag, "_rdata"}, m_rdata, rdata);
    m_hs1[g] = 1'b0;
    s_hs2    = 1'b0;
    tick();
    chk({tag, "_idle_hs2"}, 32'(m_hs2), 32'd0);
    if (rereq) m_hs1[g] = 1'b1;
  endtask

  initial begin
    int k;
    // Reset state
    tick(2);
    chk("rst_s_hs1", 32'(s_hs1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_hs2", 32'(m_hs2), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    reset = 1'b1;
    tick();

    // 1: single read from master 0
    m_hs1[0] = 1'b1; m_rw[0] = 1'b1; m_addr[0] = 8'h05;
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_s_hs1_req", 32'(s_hs1), 32'd0);
    tick();
    chk("t1_s_hs1", 32'(s_hs1), 32'd1);
    chk("t1_s_addr", 32'(s_addr), 32'h05);
    chk("t1_s_rw", 32'(s_rw), 32'd1);
    tick(2);
    s_hs2 = 1'b1; s_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_m_hs2", 32'(m_hs2), 32'b01);
    chk("t1_m_err", 32'(m_err), 32'd0);
    chk("t1_m_rdata", m_rdata, 32'hDEADBEEF);
    chk("t1_s_hs1_fall", 32'(s_hs1), 32'd0);
    m_hs1[0] = 1'b0;
    tick();
    chk("t1_wait_slave", 32'(busy), 32'd1);
    s_hs2 = 1'b0;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_hs2_clr", 32'(m_hs2), 32'd0);

    // 2: contention from reset, alternating grants
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hs1 = 2'b11; m_rw = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_xact($sformatf("t2_x%0d", i), i % 2, 32'h100 + 32'(i), i < 2);
    end

    // 3: timeout, slave never acks
    m_hs1[1] = 1'b1; m_rw[1] = 1'b0; m_addr[1] = 8'h40;
    wait_s_hs1("t3_rise");
    chk("t3_grant", 32'(grant_id), 32'd1);
    k = 0;
    while (s_hs1 === 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("t3_len", 32'(k), 32'd10);
    chk("t3_m_hs2", 32'(m_hs2), 32'b10);
    chk("t3_m_err", 32'(m_err), 32'b10);
    tick(3);
    chk("t3_err_hold", 32'(m_err), 32'b10);
    m_hs1[1] = 1'b0;
    tick();
    chk("t3_err_clr", 32'(m_err), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: ack on the timeout cycle wins
    m_hs1[0] = 1'b1; m_rw[0] = 1'b1; m_addr[0] = 8'h07;
    wait_s_hs1("t4_rise");
    tick(9);
    chk("t4_s_hs1_c9", 32'(s_hs1), 32'd1);
    s_hs2 = 1'b1; s_rdata = 32'hCAFEF00D;
    tick();
    chk("t4_s_hs1", 32'(s_hs1), 32'd0);
    chk("t4_m_hs2", 32'(m_hs2), 32'b01);
    chk("t4_m_err", 32'(m_err), 32'd0);
    chk("t4_rdata", m_rdata, 32'hCAFEF00D);
    m_hs1[0] = 1'b0; s_hs2 = 1'b0;
    tick();

    // 5: latched request frozen while master 1 changes its inputs
    m_hs1[1] = 1'b1; m_rw[1] = 1'b0; m_addr[1] = 8'h12; m_wdata[1] = 32'h11223344;
    wait_s_hs1("t5_rise");
    m_addr[1] = 8'h34; m_rw[1] = 1'b1; m_wdata[1] = 32'h55667788;
    tick(2);
    chk("t5_s_addr", 32'(s_addr), 32'h12);
    chk("t5_s_rw", 32'(s_rw), 32'd0);
    chk("t5_s_wdata", s_wdata, 32'h11223344);
    s_hs2 = 1'b1; s_rdata = 32'h0;
    tick();
    m_hs1[1] = 1'b0; s_hs2 = 1'b0;
    tick();

    // Stale slave acknowledge blocks new grants
    s_hs2 = 1'b1;
    m_hs1[0] = 1'b1; m_rw[0] = 1'b1; m_addr[0] = 8'h20;
    tick(3);
    chk("stale_busy", 32'(busy), 32'd0);
    chk("stale_s_hs1", 32'(s_hs1), 32'd0);
    s_hs2 = 1'b0;
    do_xact("stale_x", 0, 32'hA5A5A5A5, 1'b0);

    // 6: async reset in WAIT_ACK (pointer is 1 here, must return to 0)
    m_hs1[1] = 1'b1; m_addr[1] = 8'h66;
    wait_s_hs1("t6_rise");
    tick(2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_s_hs1", 32'(s_hs1), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_grant", 32'(grant_id), 32'd0);
    chk("t6_s_addr", 32'(s_addr), 32'd0);
    tick();
    reset = 1'b1;
    m_hs1[0] = 1'b1;
    do_xact("t6_ptr", 0, 32'h0BADF00D, 1'b0);
    do_xact("t6_m1", 1, 32'h600DCAFE, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
